// File: rtl/tx_buffer_pkg.sv
// Shared types and line levels for the tx_buffer transmit path.
package tx_buffer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO feeding the serialiser; head word is visible on rd_data.
// Pushes while full and pops while empty are ignored.
module tx_fifo
    import tx_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;
    logic [CW-1:0]     count_next;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_next = count - CW'(1);
        end
    end

    // Flags are registered alongside the count so they are glitch-free outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/tx_buffer.sv
// Byte FIFO plus UART-style serialiser: start, DATA_W bits LSB-first, stop.
// Define TX_PARITY_EN to insert an even parity bit between data and stop.
module tx_buffer
    import tx_buffer_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     tx_buff_ld,
    output logic                     tx_serial,
    output logic                     tx_busy,
    output logic                     buff_full,
    output logic                     buff_empty,
    output logic [$clog2(DEPTH):0]   buff_count,
    output logic                     overflow
);

    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam int unsigned NW = $clog2(DATA_W);

    tx_state_t         state;
    logic [BW-1:0]     baud_cnt;
    logic [NW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] head;
    logic              baud_last;
    logic              pop;
`ifdef TX_PARITY_EN
    logic              parity_bit;
`endif

    assign baud_last = (baud_cnt == BW'(CLKS_PER_BIT - 1));
    assign pop       = !buff_empty && ((state == IDLE) || ((state == STOP) && baud_last));
    // Combinational so the pulse coincides with the rejected load.
    assign overflow  = tx_buff_ld && buff_full;

    tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (tx_buff_ld),
        .pop     (pop),
        .wr_data (data_in),
        .rd_data (head),
        .full    (buff_full),
        .empty   (buff_empty),
        .count   (buff_count)
    );

    // Frame sequencer; a pop from IDLE or the last STOP cycle always starts a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            tx_serial  <= IDLE_LEVEL;
            tx_busy    <= 1'b0;
`ifdef TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            if ((state == IDLE) || baud_last) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + BW'(1);
            end

            if (pop) begin
                shift      <= head;
`ifdef TX_PARITY_EN
                parity_bit <= ^head;
`endif
                state      <= START;
                tx_serial  <= START_LEVEL;
                tx_busy    <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        tx_serial <= IDLE_LEVEL;
                        tx_busy   <= 1'b0;
                    end
                    START: begin
                        if (baud_last) begin
                            state     <= DATA;
                            bit_cnt   <= '0;
                            tx_serial <= shift[0];
                        end
                    end
                    DATA: begin
                        if (baud_last) begin
                            if (bit_cnt == NW'(DATA_W - 1)) begin
`ifdef TX_PARITY_EN
                                state     <= PARITY;
                                tx_serial <= parity_bit;
`else
                                state     <= STOP;
                                tx_serial <= STOP_LEVEL;
`endif
                            end else begin
                                bit_cnt   <= bit_cnt + NW'(1);
                                shift     <= shift >> 1;
                                tx_serial <= shift[1];
                            end
                        end
                    end
`ifdef TX_PARITY_EN
                    PARITY: begin
                        if (baud_last) begin
                            state     <= STOP;
                            tx_serial <= STOP_LEVEL;
                        end
                    end
`endif
                    STOP: begin
                        if (baud_last) begin
                            state   <= IDLE;
                            tx_busy <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        tx_serial <= IDLE_LEVEL;
                        tx_busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tx_buffer.sv
// Directed bench for tx_buffer with CLKS_PER_BIT=4; a line receiver decodes frames.
module tb_tx_buffer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CPB    = 4;
`ifdef TX_PARITY_EN
    localparam int NBITS  = DATA_W + 3;
`else
    localparam int NBITS  = DATA_W + 2;
`endif
    localparam int FRAME  = NBITS * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_buff_ld = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       tx_serial;
    logic       tx_busy;
    logic       buff_full;
    logic       buff_empty;
    logic [2:0] buff_count;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q[$];
    logic       rx_par[$];
    logic       rx_stop[$];
    int         rx_start[$];
    int         ov_seen = 0;

    always #5 clk = ~clk;

    tx_buffer #(
        .DATA_W       (DATA_W),
        .DEPTH        (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .tx_buff_ld (tx_buff_ld),
        .tx_serial  (tx_serial),
        .tx_busy    (tx_busy),
        .buff_full  (buff_full),
        .buff_empty (buff_empty),
        .buff_count (buff_count),
        .overflow   (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        int n;
        n = 0;
        while ((tx_busy || !buff_empty) && n < max_cycles) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, {31'd0, tx_busy}, 32'd0);
    endtask

    function automatic logic exp_line(input logic [7:0] b, input int k);
        int idx;
        idx = k / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= DATA_W) return b[idx-1];
`ifdef TX_PARITY_EN
        if (idx == DATA_W + 1) return ^b;
`endif
        return 1'b1;
    endfunction

    // Line receiver: samples each bit in its middle cycle.
    initial begin : rx
        int         k;
        int         cyc;
        int         idx;
        logic [7:0] b;
        logic       p;
        logic       s;
        k = -1;
        cyc = 0;
        b = 8'h00;
        p = 1'b0;
        s = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (overflow) ov_seen++;
            if (reset) begin
                if (k >= 0) void'(rx_start.pop_back());
                k = -1;
            end else if (k < 0) begin
                if (tx_serial == 1'b0) begin
                    k = 0;
                    rx_start.push_back(cyc);
                end
            end else begin
                k++;
                if (k % CPB == CPB / 2) begin
                    idx = k / CPB;
                    if (idx >= 1 && idx <= DATA_W) b[idx-1] = tx_serial;
                    else if (idx == NBITS - 1) s = tx_serial;
                    else p = tx_serial;
                end
                if (k == FRAME - 1) begin
                    rx_q.push_back(b);
                    rx_par.push_back(p);
                    rx_stop.push_back(s);
                    k = -1;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int lows;
        int ov0;

        // Reset state
        repeat (3) tick();
        check("rst_serial", {31'd0, tx_serial}, 32'd1);
        check("rst_busy",   {31'd0, tx_busy},   32'd0);
        check("rst_full",   {31'd0, buff_full}, 32'd0);
        check("rst_empty",  {31'd0, buff_empty}, 32'd1);
        check("rst_count",  {29'd0, buff_count}, 32'd0);
        check("rst_ovf",    {31'd0, overflow},  32'd0);
        reset = 1'b0;
        tick();
        tick();

        // Single byte 0xAA, cycle-exact line check
        data_in = 8'hAA;
        tx_buff_ld = 1'b1;
        tick();
        tx_buff_ld = 1'b0;
        check("t1_c1_count", {29'd0, buff_count}, 32'd1);
        check("t1_c1_empty", {31'd0, buff_empty}, 32'd0);
        check("t1_c1_serial", {31'd0, tx_serial}, 32'd1);
        check("t1_c1_busy", {31'd0, tx_busy}, 32'd0);
        tick();
        check("t1_c2_empty", {31'd0, buff_empty}, 32'd1);
        for (int k = 0; k < FRAME; k++) begin
            check("t1_line", {31'd0, tx_serial}, {31'd0, exp_line(8'hAA, k)});
            check("t1_busy", {31'd0, tx_busy}, 32'd1);
            tick();
        end
        check("t1_end_busy", {31'd0, tx_busy}, 32'd0);
        check("t1_end_serial", {31'd0, tx_serial}, 32'd1);
        check("t1_rx_n", rx_q.size(), 32'd1);
        check("t1_rx_byte", {24'd0, rx_q[0]}, 32'hAA);
        rx_q.delete(); rx_par.delete(); rx_stop.delete(); rx_start.delete();

        // Back-to-back frames
        tick();
        data_in = 8'h55;
        tx_buff_ld = 1'b1;
        tick();
        data_in = 8'hCC;
        tick();
        tx_buff_ld = 1'b0;
        wait_idle("t2", 400);
        check("t2_rx_n", rx_q.size(), 32'd2);
        check("t2_byte0", {24'd0, rx_q[0]}, 32'h55);
        check("t2_byte1", {24'd0, rx_q[1]}, 32'hCC);
        check("t2_gap", rx_start[1] - rx_start[0], FRAME);
        check("t2_stop0", {31'd0, rx_stop[0]}, 32'd1);
        check("t2_stop1", {31'd0, rx_stop[1]}, 32'd1);
        rx_q.delete(); rx_par.delete(); rx_stop.delete(); rx_start.delete();

        // Overflow: 0x06 hits a full buffer
        tick();
        for (int i = 0; i < 6; i++) begin
            data_in = 8'(i + 1);
            tx_buff_ld = 1'b1;
            #1;
            if (i == 4) begin
                check("t3_c4_full", {31'd0, buff_full}, 32'd0);
                check("t3_c4_ovf", {31'd0, overflow}, 32'd0);
            end
            if (i == 5) begin
                check("t3_c5_full", {31'd0, buff_full}, 32'd1);
                check("t3_c5_count", {29'd0, buff_count}, 32'd4);
                check("t3_c5_ovf", {31'd0, overflow}, 32'd1);
            end
            tick();
        end
        tx_buff_ld = 1'b0;
        #1;
        check("t3_c6_ovf", {31'd0, overflow}, 32'd0);
        check("t3_c6_count", {29'd0, buff_count}, 32'd4);
        wait_idle("t3", 800);
        check("t3_rx_n", rx_q.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check("t3_byte", {24'd0, rx_q[i]}, 32'(i + 1));
        end
        rx_q.delete(); rx_par.delete(); rx_stop.delete(); rx_start.delete();

        // Reset during data bit 3 of 0xF0 with two bytes queued
        tick();
        data_in = 8'hF0;
        tx_buff_ld = 1'b1;
        tick();
        data_in = 8'h11;
        tick();
        data_in = 8'h22;
        tick();
        tx_buff_ld = 1'b0;
        repeat (16) tick();
        check("t4_pre_line", {31'd0, tx_serial}, 32'd0);
        check("t4_pre_count", {29'd0, buff_count}, 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t4_serial", {31'd0, tx_serial}, 32'd1);
        check("t4_count", {29'd0, buff_count}, 32'd0);
        check("t4_busy", {31'd0, tx_busy}, 32'd0);
        check("t4_empty", {31'd0, buff_empty}, 32'd1);
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            if (tx_serial == 1'b0 || tx_busy) lows++;
            tick();
        end
        check("t4_quiet", lows, 32'd0);
        check("t4_rx_n", rx_q.size(), 32'd0);
        rx_q.delete(); rx_par.delete(); rx_stop.delete(); rx_start.delete();

`ifdef TX_PARITY_EN
        // Parity bit values
        data_in = 8'h0F;
        tx_buff_ld = 1'b1;
        tick();
        data_in = 8'h07;
        tick();
        tx_buff_ld = 1'b0;
        wait_idle("t5", 400);
        check("t5_rx_n", rx_q.size(), 32'd2);
        check("t5_byte0", {24'd0, rx_q[0]}, 32'h0F);
        check("t5_par0", {31'd0, rx_par[0]}, 32'd0);
        check("t5_byte1", {24'd0, rx_q[1]}, 32'h07);
        check("t5_par1", {31'd0, rx_par[1]}, 32'd1);
        rx_q.delete(); rx_par.delete(); rx_stop.delete(); rx_start.delete();
`endif

        // Pointer wrap-around over 12 paced bytes
        ov0 = ov_seen;
        for (int i = 0; i < 12; i++) begin
            data_in = 8'h10 + 8'(i);
            tx_buff_ld = 1'b1;
            tick();
            tx_buff_ld = 1'b0;
            repeat (31) tick();
        end
        wait_idle("t6", 800);
        check("t6_rx_n", rx_q.size(), 32'd12);
        for (int i = 0; i < 12; i++) begin
            check("t6_byte", {24'd0, rx_q[i]}, 32'h10 + 32'(i));
        end
        check("t6_no_ovf", ov_seen - ov0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
